fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage of the Ak-16b CPU, directly upstream of imem.
//  Owns the program counter and drives imem addr. Captures the asynchronously
//  read instr together with its PC into a small prefetch FIFO.
//  Presents {pc, instr} to decode through a valid/ready handshake.
//  Honours branch/jump redirects (flush + PC load) and an external halt.
// PARAMETERS
//  RESET_PC    16'h0000  PC value loaded on reset
//  FIFO_DEPTH  2         prefetch entries; power of two, >=2
//  CNT_W       2         width of fifo_count; $clog2(FIFO_DEPTH)+1
// PORTS
//  clk            in   1   rising-edge clock; single clock domain
//  rst_n          in   1   asynchronous, active-low reset
//  imem_addr      out  16  address to imem; combinational copy of pc register
//  imem_instr     in   16  instruction word from imem, same cycle as imem_addr
//  halt           in   1   1 = stop fetching; PC holds, FIFO still drains
//  redirect_valid in   1   branch/jump taken this cycle
//  redirect_pc    in   16  target PC, sampled when redirect_valid=1
//  if_valid       out  1   head entry valid to decode
//  if_ready       in   1   decode accepts head entry this cycle
//  if_instr       out  16  head instruction
//  if_pc          out  16  PC of head instruction
//  fifo_count     out  CNT_W  occupied entries (debug/perf)
// BEHAVIOUR
//  - Reset (rst_n=0, async): pc=RESET_PC; FIFO count=0; if_valid=0;
//    if_instr=0; if_pc=0; fifo_count=0. Storage contents need not be cleared.
//  - imem_addr = pc at all times, including during halt.
//  - pop  = if_valid & if_ready.
//  - push = !halt & !redirect_valid & (count<FIFO_DEPTH | pop).
//  - On push: entry {pc, imem_instr} is written at the tail; pc <= pc+1.
//    pc is 16-bit and wraps 16'hFFFF -> 16'h0000. imem decodes only addr[7:0].
//  - if_valid = (count!=0). if_instr and if_pc are the head entry and are
//    forced to 0 when count==0.
//  - Fetch latency: an instruction pushed in cycle N is visible at the outputs
//    in cycle N+1 (registered). After reset release, mem[RESET_PC] shows
//    if_valid=1 one edge after the first clock.
//  - Full FIFO with pop: push and pop in the same cycle; count is unchanged.
//    Full FIFO without pop: no push; pc holds.
//  - Empty FIFO: if_ready is ignored; count never underflows.
//  - Redirect has highest priority. In cycle N with redirect_valid=1:
//    flush (count<=0, pointers reset); pc<=redirect_pc; no push; any pop in
//    that cycle is a don't-care for decode. if_valid=0 in cycle N+1.
//    Target is pushed in N+1 and if_valid=1 with if_pc=redirect_pc in N+2.
//  - Redirect while halted: flush and pc load still occur; fetch resumes from
//    the target only when halt falls.
//  - Halt: no push; pc frozen; pops continue until the FIFO is empty.
//  - Reset mid-operation overrides everything asynchronously. The first fetch
//    restarts at RESET_PC.
//  - No combinational path from if_ready or redirect_valid to imem_addr.
//    Paths from if_ready to internal push are allowed.
// STRUCTURE
//  - Shared header ak16_defs.vh: XLEN=16, INSTR_W=16, IMEM_AW=8,
//    RESET_VECTOR=16'h0000.
//  - Sub-module fetch_fifo: parameterised synchronous FIFO.
//    Ports: width, depth, push/pop/flush, count, head data.
//    Flush dominates push and pop. fetch_unit adds the PC register and
//    push/redirect control around it.
// TESTING
//  (program.hex mem[i]=16'hA000+i unless stated)
//  1 Reset, if_ready=1 continuous -> if_pc 0,1,2,3... on consecutive cycles,
//    if_instr=A000+pc; fifo_count<=1.
//  2 if_ready=0 for 5 cycles -> fifo_count saturates at 2; pc stops at 2;
//    if_pc held at 0. Raise if_ready -> pcs 0,1,2 in order, with no gap or
//    duplicate.
//  3 Redirect to 16'h0040 while FIFO full -> next cycle if_valid=0,
//    fifo_count=0. Following cycle: if_pc=0040, if_instr=A040.
//  4 halt=1 with 2 entries, if_ready=1 -> two pops, then if_valid=0;
//    imem_addr constant. halt=0 -> fetch resumes at the held pc.
//  5 Redirect to 16'hFFFF, run 2 instrs -> if_pc FFFF then 0000;
//    instr=mem[FF], then mem[00].
//  6 Assert rst_n=0 mid-stream between clock edges -> outputs are zero
//    immediately. After release, if_pc=RESET_PC first.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the Ak-16b fetch stage.
//   XLEN / INSTR_W : architectural PC and instruction widths
//   IMEM_AW        : number of address bits imem actually decodes
//   RESET_VECTOR   : default PC after reset
//   fetch_entry_t  : one prefetch FIFO entry, {pc, instr}
package fetch_unit_pkg;

    localparam int unsigned XLEN         = 16;
    localparam int unsigned INSTR_W      = 16;
    localparam int unsigned IMEM_AW      = 8;
    localparam logic [15:0] RESET_VECTOR = 16'h0000;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Sequential PC step; 16-bit arithmetic wraps FFFF -> 0000.
    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO used as the fetch prefetch buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the FIFO; dominates push and pop
//   push       : write push_data at the tail (ignored when full unless popping)
//   pop        : retire the head entry (ignored when empty)
//   push_data  : entry to write
//   count      : occupied entries
//   head_data  : head entry, zero when empty
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_data
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty, full, pop_en, push_en;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop_en  = pop & ~empty;
    // A full FIFO can still accept a write when the head leaves in the same cycle.
    assign push_en = push & (~full | pop_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push_en, pop_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_en && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign count     = count_q;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the Ak-16b CPU.
// Owns the PC, drives imem, and buffers {pc, instr} pairs in a prefetch FIFO
// that decode drains through a valid/ready handshake.
//   clk, rst_n     : clock, asynchronous active-low reset
//   imem_addr      : imem address, always the PC register
//   imem_instr     : instruction returned by imem for imem_addr
//   halt           : stop fetching; PC holds, FIFO still drains
//   redirect_valid : branch/jump taken; flush and load redirect_pc
//   redirect_pc    : redirect target
//   if_valid       : head entry valid to decode
//   if_ready       : decode accepts the head entry
//   if_instr/if_pc : head entry, zero when the FIFO is empty
//   fifo_count     : occupied entries
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = RESET_VECTOR,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [XLEN-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_instr,
    input  logic                halt,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [XLEN-1:0]     if_pc,
    output logic [CNT_W-1:0]    fifo_count
);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             push, pop;
    logic [CNT_W-1:0] count;
    fetch_entry_t     tail_entry, head_entry;

    assign pop  = if_valid & if_ready;
    // Redirect wins over everything; a slot frees up when decode pops the head.
    assign push = ~halt & ~redirect_valid & ((count < CNT_W'(FIFO_DEPTH)) | pop);

    assign tail_entry = '{pc: pc_q, instr: imem_instr};

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (push) begin
            pc_d = pc_inc(pc_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .pop       (pop),
        .push_data (tail_entry),
        .count     (count),
        .head_data (head_entry)
    );

    // Only the PC register reaches imem, so if_ready/redirect never feed it.
    assign imem_addr  = pc_q;
    assign if_valid   = (count != '0);
    assign if_instr   = head_entry.instr;
    assign if_pc      = head_entry.pc;
    assign fifo_count = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. imem holds mem[i] = 16'hA000 + i and decodes
// only addr[7:0]. Inputs change and outputs are sampled 1 time unit after
// each rising edge.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        halt;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [1:0]  fifo_count;

    int vectors;
    int errors;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fifo_count     (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_instr = 16'hA000 + {8'h00, imem_addr[7:0]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [50:0] exp;
        halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0; if_ready = 1'b1;
        apply_reset();
        exp = {1'b0, 16'h0, 16'h0, 2'd0, 16'h0000};
        vectors++;
        if ({if_valid, if_pc, if_instr, fifo_count, imem_addr} !== exp) begin
            $display("FAIL reset_state: got %h want %h",
                     {if_valid, if_pc, if_instr, fifo_count, imem_addr}, exp);
            errors++;
        end
    endtask

    task automatic test_stream();
        logic [34:0] exp;
        apply_reset();
        if_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            exp = {1'b1, 16'(k), 16'hA000 + 16'(k), 2'd1};
            vectors++;
            if ({if_valid, if_pc, if_instr, fifo_count} !== exp) begin
                $display("FAIL stream_%0d: got %h want %h", k,
                         {if_valid, if_pc, if_instr, fifo_count}, exp);
                errors++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [34:0] exp;
        int          fill;
        apply_reset();
        if_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            fill = (k < 2) ? k : 2;
            exp  = {2'(fill), 16'(fill), 1'b1, 16'h0000};
            vectors++;
            if ({fifo_count, imem_addr, if_valid, if_pc} !== exp) begin
                $display("FAIL stall_%0d: got %h want %h", k,
                         {fifo_count, imem_addr, if_valid, if_pc}, exp);
                errors++;
            end
        end
        // Head is pc 0 now; each edge with ready retires one, no gap/duplicate.
        if_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp = {2'd2, 16'(k), 16'hA000 + 16'(k), 1'b1};
            vectors++;
            if ({fifo_count, if_pc, if_instr, if_valid} !== exp) begin
                $display("FAIL drain_%0d: got %h want %h", k,
                         {fifo_count, if_pc, if_instr, if_valid}, exp);
                errors++;
            end
        end
    endtask

    task automatic test_redirect_full();
        logic [34:0] exp;
        apply_reset();
        if_ready = 1'b0;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        tick();
        redirect_valid = 1'b0;
        exp = {1'b0, 2'd0, 16'h0040, 16'h0000};
        vectors++;
        if ({if_valid, fifo_count, imem_addr, if_pc} !== exp) begin
            $display("FAIL redir_flush: got %h want %h",
                     {if_valid, fifo_count, imem_addr, if_pc}, exp);
            errors++;
        end
        tick();
        exp = {1'b1, 16'h0040, 16'hA040, 2'd1};
        vectors++;
        if ({if_valid, if_pc, if_instr, fifo_count} !== exp) begin
            $display("FAIL redir_target: got %h want %h",
                     {if_valid, if_pc, if_instr, fifo_count}, exp);
            errors++;
        end
    endtask

    task automatic test_halt();
        logic [34:0] exp;
        apply_reset();
        if_ready = 1'b0;
        tick();
        tick();
        halt     = 1'b1;
        if_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            // Two pops retire pc 0 and 1, then the FIFO stays empty.
            exp = (k == 1) ? {1'b1, 2'd1, 16'h0001, 16'h0002}
                           : {1'b0, 2'd0, 16'h0000, 16'h0002};
            vectors++;
            if ({if_valid, fifo_count, if_pc, imem_addr} !== exp) begin
                $display("FAIL halt_drain_%0d: got %h want %h", k,
                         {if_valid, fifo_count, if_pc, imem_addr}, exp);
                errors++;
            end
        end
        halt = 1'b0;
        tick();
        exp = {1'b1, 2'd1, 16'h0002, 16'h0003};
        vectors++;
        if ({if_valid, fifo_count, if_pc, imem_addr} !== exp) begin
            $display("FAIL halt_resume: got %h want %h",
                     {if_valid, fifo_count, if_pc, imem_addr}, exp);
            errors++;
        end
        // Redirect while halted: flush and PC load, but no fetch until halt drops.
        halt           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0010;
        tick();
        redirect_valid = 1'b0;
        tick();
        exp = {1'b0, 2'd0, 16'h0000, 16'h0010};
        vectors++;
        if ({if_valid, fifo_count, if_pc, imem_addr} !== exp) begin
            $display("FAIL halt_redir: got %h want %h",
                     {if_valid, fifo_count, if_pc, imem_addr}, exp);
            errors++;
        end
        halt = 1'b0;
        tick();
        exp = {1'b1, 2'd1, 16'h0010, 16'h0011};
        vectors++;
        if ({if_valid, fifo_count, if_pc, imem_addr} !== exp) begin
            $display("FAIL halt_redir_resume: got %h want %h",
                     {if_valid, fifo_count, if_pc, imem_addr}, exp);
            errors++;
        end
    endtask

    task automatic test_wrap();
        logic [32:0] exp;
        apply_reset();
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        tick();
        redirect_valid = 1'b0;
        tick();
        exp = {1'b1, 16'hFFFF, 16'hA0FF};
        vectors++;
        if ({if_valid, if_pc, if_instr} !== exp) begin
            $display("FAIL wrap_ffff: got %h want %h", {if_valid, if_pc, if_instr}, exp);
            errors++;
        end
        tick();
        exp = {1'b1, 16'h0000, 16'hA000};
        vectors++;
        if ({if_valid, if_pc, if_instr} !== exp) begin
            $display("FAIL wrap_0000: got %h want %h", {if_valid, if_pc, if_instr}, exp);
            errors++;
        end
    endtask

    task automatic test_async_reset();
        logic [50:0] exp;
        logic [32:0] exp2;
        apply_reset();
        if_ready = 1'b1;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        exp = {1'b0, 16'h0, 16'h0, 2'd0, 16'h0000};
        vectors++;
        if ({if_valid, if_pc, if_instr, fifo_count, imem_addr} !== exp) begin
            $display("FAIL async_reset: got %h want %h",
                     {if_valid, if_pc, if_instr, fifo_count, imem_addr}, exp);
            errors++;
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            exp2 = {1'b1, 16'(k), 16'hA000 + 16'(k)};
            vectors++;
            if ({if_valid, if_pc, if_instr} !== exp2) begin
                $display("FAIL post_reset_%0d: got %h want %h", k,
                         {if_valid, if_pc, if_instr}, exp2);
                errors++;
            end
        end
    endtask

    initial begin
        vectors        = 0;
        errors         = 0;
        rst_n          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        if_ready       = 1'b0;
        #3;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
